// File: rtl/bht_btb_predictor_if.sv
// Branch predictor bus: IF-stage lookup, EX-stage training, flush and statistics.
//   master : fetch/execute side (drives lookup_pc, upd_*, flush_tables; reads pred_*, stat_*)
//   slave  : predictor side (reads lookup/update/flush; drives pred_* and stat_*)
interface bht_btb_predictor_if #(
  parameter int unsigned XLEN      = 64,
  parameter int unsigned STAT_BITS = 32
);
  logic [XLEN-1:0]      lookup_pc;
  logic                 pred_hit;
  logic                 pred_taken;
  logic [XLEN-1:0]      pred_target;
  logic                 upd_valid;
  logic [XLEN-1:0]      upd_pc;
  logic                 upd_taken;
  logic [XLEN-1:0]      upd_target;
  logic                 upd_mispredict;
  logic                 flush_tables;
  logic [STAT_BITS-1:0] stat_branches;
  logic [STAT_BITS-1:0] stat_mispredicts;

  modport master (
    output lookup_pc, upd_valid, upd_pc, upd_taken, upd_target, upd_mispredict, flush_tables,
    input  pred_hit, pred_taken, pred_target, stat_branches, stat_mispredicts
  );

  modport slave (
    input  lookup_pc, upd_valid, upd_pc, upd_taken, upd_target, upd_mispredict, flush_tables,
    output pred_hit, pred_taken, pred_target, stat_branches, stat_mispredicts
  );
endinterface

// File: rtl/bht_btb_predictor.sv
// Dynamic branch predictor: direct-mapped table of saturating direction counters
// combined with a tagged target buffer.
//   clk, rst : system clock, synchronous active-high reset
//   bus      : slave side of bht_btb_predictor_if
//              lookup_pc -> pred_hit/pred_taken/pred_target (combinational, registered state only)
//              upd_*     -> training on the posedge where upd_valid=1
//              flush_tables invalidates every entry; stat_* count branches/mispredicts
module bht_btb_predictor #(
  parameter int unsigned XLEN      = 64,
  parameter int unsigned ENTRIES   = 16,
  parameter int unsigned CTR_BITS  = 2,
  parameter int unsigned TAG_BITS  = 8,
  parameter int unsigned STAT_BITS = 32
) (
  input  logic                   clk,
  input  logic                   rst,
  bht_btb_predictor_if.slave     bus
);
  localparam int unsigned IDX_W = $clog2(ENTRIES);

  localparam logic [CTR_BITS-1:0] CTR_WNT = CTR_BITS'((1 << (CTR_BITS - 1)) - 1);
  localparam logic [CTR_BITS-1:0] CTR_WT  = CTR_BITS'(1 << (CTR_BITS - 1));
  localparam logic [CTR_BITS-1:0] CTR_MAX = '1;

  logic                 valid_q  [ENTRIES];
  logic                 valid_d  [ENTRIES];
  logic [TAG_BITS-1:0]  tag_q    [ENTRIES];
  logic [TAG_BITS-1:0]  tag_d    [ENTRIES];
  logic [XLEN-1:0]      target_q [ENTRIES];
  logic [XLEN-1:0]      target_d [ENTRIES];
  logic [CTR_BITS-1:0]  ctr_q    [ENTRIES];
  logic [CTR_BITS-1:0]  ctr_d    [ENTRIES];

  logic [STAT_BITS-1:0] branches_q;
  logic [STAT_BITS-1:0] branches_d;
  logic [STAT_BITS-1:0] mispredicts_q;
  logic [STAT_BITS-1:0] mispredicts_d;

  logic [IDX_W-1:0]     lk_idx;
  logic [TAG_BITS-1:0]  lk_tag;
  logic [IDX_W-1:0]     up_idx;
  logic [TAG_BITS-1:0]  up_tag;
  logic                 lk_hit;
  logic                 up_hit;

  assign lk_idx = bus.lookup_pc[IDX_W+1:2];
  assign lk_tag = bus.lookup_pc[IDX_W+TAG_BITS+1:IDX_W+2];
  assign up_idx = bus.upd_pc[IDX_W+1:2];
  assign up_tag = bus.upd_pc[IDX_W+TAG_BITS+1:IDX_W+2];

  // Lookup sees only registered state, so a same-cycle update is not bypassed.
  assign lk_hit = valid_q[lk_idx] && (tag_q[lk_idx] == lk_tag);
  assign up_hit = valid_q[up_idx] && (tag_q[up_idx] == up_tag);

  assign bus.pred_hit         = lk_hit;
  assign bus.pred_taken       = lk_hit && ctr_q[lk_idx][CTR_BITS-1];
  assign bus.pred_target      = (lk_hit && ctr_q[lk_idx][CTR_BITS-1]) ? target_q[lk_idx]
                                                                      : bus.lookup_pc + XLEN'(4);
  assign bus.stat_branches    = branches_q;
  assign bus.stat_mispredicts = mispredicts_q;

  always_comb begin
    valid_d  = valid_q;
    tag_d    = tag_q;
    target_d = target_q;
    ctr_d    = ctr_q;

    if (bus.flush_tables) begin
      for (int unsigned i = 0; i < ENTRIES; i++) begin
        valid_d[i] = 1'b0;
        ctr_d[i]   = CTR_WNT;
      end
    end else if (bus.upd_valid) begin
      if (up_hit) begin
        if (bus.upd_taken) begin
          if (ctr_q[up_idx] != CTR_MAX) begin
            ctr_d[up_idx] = ctr_q[up_idx] + CTR_BITS'(1);
          end
          target_d[up_idx] = bus.upd_target;
        end else if (ctr_q[up_idx] != '0) begin
          ctr_d[up_idx] = ctr_q[up_idx] - CTR_BITS'(1);
        end
      end else if (bus.upd_taken) begin
        // Taken miss replaces whatever occupies the slot; not-taken misses never allocate.
        valid_d[up_idx]  = 1'b1;
        tag_d[up_idx]    = up_tag;
        target_d[up_idx] = bus.upd_target;
        ctr_d[up_idx]    = CTR_WT;
      end
    end
  end

  // Statistics count independently of flush; both saturate at all-ones.
  always_comb begin
    branches_d    = branches_q;
    mispredicts_d = mispredicts_q;
    if (bus.upd_valid && (branches_q != '1)) begin
      branches_d = branches_q + STAT_BITS'(1);
    end
    if (bus.upd_valid && bus.upd_mispredict && (mispredicts_q != '1)) begin
      mispredicts_d = mispredicts_q + STAT_BITS'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int unsigned i = 0; i < ENTRIES; i++) begin
        valid_q[i] <= 1'b0;
        ctr_q[i]   <= CTR_WNT;
      end
      branches_q    <= '0;
      mispredicts_q <= '0;
    end else begin
      valid_q       <= valid_d;
      ctr_q         <= ctr_d;
      branches_q    <= branches_d;
      mispredicts_q <= mispredicts_d;
    end
  end

  // Tags and targets carry no reset; they are only meaningful behind valid.
  always_ff @(posedge clk) begin
    if (!rst) begin
      tag_q    <= tag_d;
      target_q <= target_d;
    end
  end
endmodule

// File: tb/tb_bht_btb_predictor.sv
module tb_bht_btb_predictor;
  logic clk;
  logic rst;

  int unsigned checks;
  int unsigned errors;

  bht_btb_predictor_if #(.XLEN(64), .STAT_BITS(32)) u_if  ();
  bht_btb_predictor_if #(.XLEN(64), .STAT_BITS(4))  u_if4 ();

  bht_btb_predictor #(
    .XLEN(64), .ENTRIES(16), .CTR_BITS(2), .TAG_BITS(8), .STAT_BITS(32)
  ) u_dut (
    .clk (clk),
    .rst (rst),
    .bus (u_if.slave)
  );

  bht_btb_predictor #(
    .XLEN(64), .ENTRIES(16), .CTR_BITS(2), .TAG_BITS(8), .STAT_BITS(4)
  ) u_dut4 (
    .clk (clk),
    .rst (rst),
    .bus (u_if4.slave)
  );

  // Narrow-statistics instance sees identical stimulus.
  assign u_if4.lookup_pc      = u_if.lookup_pc;
  assign u_if4.upd_valid      = u_if.upd_valid;
  assign u_if4.upd_pc         = u_if.upd_pc;
  assign u_if4.upd_taken      = u_if.upd_taken;
  assign u_if4.upd_target     = u_if.upd_target;
  assign u_if4.upd_mispredict = u_if.upd_mispredict;
  assign u_if4.flush_tables   = u_if.flush_tables;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [63:0] lookup_pc;
    logic        upd_valid;
    logic [63:0] upd_pc;
    logic        upd_taken;
    logic [63:0] upd_target;
    logic        upd_mis;
    logic        flush;
    logic        exp_hit;
    logic        exp_taken;
    logic [63:0] exp_target;
    int unsigned exp_br;
    int unsigned exp_mis;
  } vec_t;

  typedef struct {
    logic        hit;
    logic        taken;
    logic [63:0] target;
    int unsigned br;
    int unsigned mis;
  } exp_t;

  exp_t sb[$];
  vec_t vecs[20];

  function automatic vec_t mk(input logic [63:0] lpc, input logic uv, input logic [63:0] upc,
                              input logic ut, input logic [63:0] utgt, input logic um,
                              input logic fl, input logic eh, input logic et,
                              input logic [63:0] etgt, input int unsigned ebr,
                              input int unsigned emis);
    vec_t v;
    v.lookup_pc = lpc;  v.upd_valid = uv;  v.upd_pc = upc;  v.upd_taken = ut;
    v.upd_target = utgt; v.upd_mis = um;   v.flush = fl;
    v.exp_hit = eh;  v.exp_taken = et;  v.exp_target = etgt;
    v.exp_br = ebr;  v.exp_mis = emis;
    return v;
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  function automatic int unsigned sat15(input int unsigned v);
    return (v > 15) ? 15 : v;
  endfunction

  // Drive one cycle of stimulus at negedge; expectations describe pre-update state.
  task automatic apply(input string tag, input vec_t v);
    exp_t e;
    @(negedge clk);
    u_if.lookup_pc      = v.lookup_pc;
    u_if.upd_valid      = v.upd_valid;
    u_if.upd_pc         = v.upd_pc;
    u_if.upd_taken      = v.upd_taken;
    u_if.upd_target     = v.upd_target;
    u_if.upd_mispredict = v.upd_mis;
    u_if.flush_tables   = v.flush;
    sb.push_back('{v.exp_hit, v.exp_taken, v.exp_target, v.exp_br, v.exp_mis});
    #1;
    if (sb.size() == 0) begin
      checks++;
      errors++;
      $display("FAIL %s scoreboard empty", tag);
    end else begin
      e = sb.pop_front();
      check({tag, ".hit"},    {63'd0, u_if.pred_hit},   {63'd0, e.hit});
      check({tag, ".taken"},  {63'd0, u_if.pred_taken}, {63'd0, e.taken});
      check({tag, ".target"}, u_if.pred_target,         e.target);
      check({tag, ".br"},     {32'd0, u_if.stat_branches},    64'(e.br));
      check({tag, ".mis"},    {32'd0, u_if.stat_mispredicts}, 64'(e.mis));
      check({tag, ".br4"},    {60'd0, u_if4.stat_branches},    64'(sat15(e.br)));
      check({tag, ".mis4"},   {60'd0, u_if4.stat_mispredicts}, 64'(sat15(e.mis)));
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

  initial begin
    checks = 0;
    errors = 0;

    //          lookup   uv upd_pc  tk tgt     mis fl  hit tk exp_tgt  br  mis
    vecs[0]  = mk(64'h100, 0, 64'h0,   0, 64'h0,   0, 0,  0, 0, 64'h104, 0,  0);
    vecs[1]  = mk(64'h100, 1, 64'h100, 1, 64'h40,  1, 0,  0, 0, 64'h104, 0,  0);
    vecs[2]  = mk(64'h100, 1, 64'h200, 0, 64'h0,   0, 0,  1, 1, 64'h40,  1,  1);
    vecs[3]  = mk(64'h200, 1, 64'h100, 1, 64'h40,  0, 0,  0, 0, 64'h204, 2,  1);
    vecs[4]  = mk(64'h4100,1, 64'h100, 1, 64'h44,  0, 0,  1, 1, 64'h40,  3,  1);
    vecs[5]  = mk(64'h100, 1, 64'h100, 1, 64'h44,  0, 0,  1, 1, 64'h44,  4,  1);
    vecs[6]  = mk(64'h100, 1, 64'h100, 0, 64'h0,   1, 0,  1, 1, 64'h44,  5,  1);
    vecs[7]  = mk(64'h100, 1, 64'h100, 0, 64'h0,   0, 0,  1, 1, 64'h44,  6,  2);
    vecs[8]  = mk(64'h100, 1, 64'h100, 0, 64'h0,   0, 0,  1, 0, 64'h104, 7,  2);
    vecs[9]  = mk(64'h100, 1, 64'h100, 0, 64'h0,   0, 0,  1, 0, 64'h104, 8,  2);
    vecs[10] = mk(64'h100, 1, 64'h100, 1, 64'h48,  1, 0,  1, 0, 64'h104, 9,  2);
    vecs[11] = mk(64'h100, 1, 64'h100, 1, 64'h48,  0, 0,  1, 0, 64'h104, 10, 3);
    vecs[12] = mk(64'h100, 1, 64'h140, 1, 64'h80,  0, 0,  1, 1, 64'h48,  11, 3);
    vecs[13] = mk(64'h100, 0, 64'h0,   0, 64'h0,   0, 0,  0, 0, 64'h104, 12, 3);
    vecs[14] = mk(64'h140, 1, 64'h108, 1, 64'h500, 0, 0,  1, 1, 64'h80,  12, 3);
    vecs[15] = mk(64'h108, 1, 64'h140, 1, 64'h84,  1, 1,  1, 1, 64'h500, 13, 3);
    vecs[16] = mk(64'h108, 0, 'x,      'x, 'x,     'x, 0, 0, 0, 64'h10c, 14, 4);
    vecs[17] = mk(64'h140, 0, 64'h140, 1, 64'h90,  1, 0,  0, 0, 64'h144, 14, 4);
    vecs[18] = mk(64'h140, 0, 64'h0,   0, 64'h0,   0, 0,  0, 0, 64'h144, 14, 4);
    vecs[19] = mk(64'hffff_ffff_ffff_fffc, 0, 64'h0, 0, 64'h0, 0, 0, 0, 0, 64'h0, 14, 4);

    rst = 1'b1;
    u_if.lookup_pc      = 64'h100;
    u_if.upd_valid      = 1'b0;
    u_if.upd_pc         = '0;
    u_if.upd_taken      = 1'b0;
    u_if.upd_target     = '0;
    u_if.upd_mispredict = 1'b0;
    u_if.flush_tables   = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;

    for (int i = 0; i < 20; i++) begin
      apply($sformatf("vec%0d", i), vecs[i]);
    end

    // Statistics saturation: 20 mispredicting not-taken updates to an empty slot.
    for (int i = 0; i < 20; i++) begin
      apply($sformatf("sat%0d", i),
            mk(64'h200, 1, 64'h200, 0, 64'h0, 1, 0, 0, 0, 64'h204, 14 + i, 4 + i));
    end
    apply("sat_end", mk(64'h200, 0, 64'h0, 0, 64'h0, 0, 0, 0, 0, 64'h204, 34, 24));

    // Reset asserted alongside a taken update: update is discarded, stats cleared.
    @(negedge clk);
    rst                 = 1'b1;
    u_if.upd_valid      = 1'b1;
    u_if.upd_pc         = 64'h10c;
    u_if.upd_taken      = 1'b1;
    u_if.upd_target     = 64'h900;
    u_if.upd_mispredict = 1'b1;
    @(negedge clk);
    rst                 = 1'b0;
    u_if.upd_valid      = 1'b0;
    apply("rst_mid", mk(64'h10c, 0, 64'h0, 0, 64'h0, 0, 0, 0, 0, 64'h110, 0, 0));

    // Allocation after reset still works and counts.
    apply("post_rst_alloc", mk(64'h10c, 1, 64'h10c, 1, 64'h900, 0, 0, 0, 0, 64'h110, 0, 0));
    apply("post_rst_hit",   mk(64'h10c, 0, 64'h0,   0, 64'h0,   0, 0, 1, 1, 64'h900, 1, 0));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/bht_btb_predictor.md
Name: bht_btb_predictor

Overview:
Parametrised dynamic branch predictor for the pipelined core. It combines a direct-mapped branch history table of saturating counters with a tagged branch target buffer. It is queried combinationally from the IF stage with the fetch PC. It is trained from the EX stage when a branch resolves, and keeps branch/mispredict statistics counters. It supersedes the single-bit predictor: it supplies a predicted target, not just a direction.

Parameters:
XLEN, 64, PC and target width.
ENTRIES, 16, table depth; power of two, >= 2. IDX_W = log2(ENTRIES).
CTR_BITS, 2, saturating counter width, 1..4.
TAG_BITS, 8, stored tag width, >= 1; IDX_W+TAG_BITS+2 <= XLEN.
STAT_BITS, 32, statistics counter width.

Ports:
clk  in  1  system clock.
rst  in  1  synchronous active-high reset.
lookup_pc  in  XLEN  IF-stage fetch PC.
pred_hit  out  1  valid entry with matching tag for lookup_pc.
pred_taken  out  1  predicted direction.
pred_target  out  XLEN  predicted next PC.
upd_valid  in  1  EX-stage branch resolved this cycle.
upd_pc  in  XLEN  PC of the resolved branch.
upd_taken  in  1  actual branch outcome.
upd_target  in  XLEN  actual taken target.
upd_mispredict  in  1  EX detected a misprediction; qualified by upd_valid.
flush_tables  in  1  invalidate all entries; statistics are kept.
stat_branches  out  STAT_BITS  resolved-branch count.
stat_mispredicts  out  STAT_BITS  misprediction count.

Behaviour:
- Index and tag: idx = pc[IDX_W+1:2]; tag = pc[IDX_W+TAG_BITS+1:IDX_W+2]. Both are computed the same way for lookup_pc and upd_pc.
- Per-entry state: valid (1 bit), tag, target (XLEN), ctr (CTR_BITS).
- Lookup is combinational with zero latency and reads registered table state only.
  - pred_hit = valid[idx] && tag match.
  - pred_taken = pred_hit && ctr[idx] MSB set.
  - pred_target = upd-independent; equals target[idx] if pred_taken, else lookup_pc+4 (modulo 2^XLEN).
- Reset (rst=1 at posedge):
  - all valid=0; all ctr=WNT, where WNT = 2^(CTR_BITS-1)-1 and WT = 2^(CTR_BITS-1); tags and targets are don't-care.
  - stats=0.
  - Consequent outputs: pred_hit=0, pred_taken=0, pred_target=lookup_pc+4.
  - rst has priority over flush_tables and upd_valid. Reset mid-training discards the update in that cycle.
- flush_tables=1 at posedge: all valid=0, all ctr=WNT; stats unchanged. It has priority over a same-cycle table update, but the stat increment for that update still occurs.
- Update, effective on the posedge where upd_valid=1:
  - Hit, upd_taken=1: ctr increments, saturating at 2^CTR_BITS-1; target <= upd_target.
  - Hit, upd_taken=0: ctr decrements, saturating at 0; target unchanged.
  - Miss and upd_taken=1: allocate (overwrite any aliasing entry). valid=1, tag, target=upd_target, ctr=WT.
  - Miss and upd_taken=0: table unchanged (no allocation of not-taken branches).
- Statistics:
  - stat_branches increments per upd_valid.
  - stat_mispredicts increments per upd_valid && upd_mispredict.
  - Both saturate at all-ones; no wrap.
- Simultaneous lookup and update on the same idx: lookup returns pre-update state. No bypass. The new state is visible from the next cycle.
- CTR_BITS=1: WNT=0, WT=1. The counter behaves as a last-outcome bit.
- upd_* are ignored when upd_valid=0; X on them must not corrupt state.
- No stall input: the predictor is stateless per lookup, so IF stalls need no handling.

Test Plan:
- Reset, then lookup_pc=0x100 -> pred_hit=0, pred_taken=0, pred_target=0x104; stats=0.
- Update pc=0x100, taken, target=0x40. Next cycle lookup 0x100 -> hit=1, taken=1, target=0x40. Update pc=0x200, not-taken -> lookup 0x200 gives hit=0.
- Counter saturation (CTR_BITS=2):
  - After allocation, 3 further taken updates to 0x100 -> ctr=3.
  - Then 1 not-taken -> still predicts taken (ctr=2).
  - Second not-taken -> pred_taken=0, pred_target=0x104.
- Aliasing (ENTRIES=16):
  - 0x100 allocated; taken update to 0x140 (same idx, different tag) replaces it -> lookup 0x100 hit=0.
  - PCs differing only above the tag field alias and hit.
- Same-cycle lookup and update of 0x100 (first taken) -> that cycle hit=0; next cycle hit=1.
- Flush and statistics:
  - flush_tables with upd_valid=1, upd_mispredict=1 -> all lookups miss; stat_branches and stat_mispredicts each +1.
  - With STAT_BITS=4, 20 mispredicting updates -> both stats read 15.
